// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART-to-SRAM boot loader.
// Optional checksum stage is enabled with UART_MEM_LOADER_CHECKSUM_EN.
package uart_mem_loader_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h53;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_WORD  = 4'b1111;

endpackage

// File: rtl/uart_mem_loader_lane.sv
// Byte-lane counter, word counter and SRAM address generator for the loader.
// Produces the registered byte enable / word address for each payload byte.
module uart_mem_loader_lane
    import uart_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BPW       = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              clear,
    input  logic              fire,
    output logic [BPW-1:0]    mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W:0]   words_loaded,
    output logic              word_done
);

    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [LANE_W-1:0] lane;
    logic [ADDR_W-1:0] word_addr;

    assign word_done = fire && (lane == LANE_W'(BPW - 1));

    // word_addr tracks BASE + words_loaded so the write address is ready without an adder in the output path
    always_ff @(posedge clk) begin
        if (!nRST) begin
            lane         <= '0;
            words_loaded <= '0;
            word_addr    <= BASE;
            mem_be       <= '0;
            mem_addr     <= BASE;
        end else begin
            mem_be <= fire ? (BPW'(1) << lane) : '0;
            if (fire) begin
                mem_addr <= word_addr;
            end
            if (clear) begin
                lane         <= '0;
                words_loaded <= '0;
                word_addr    <= BASE;
            end else if (fire) begin
                if (word_done) begin
                    lane         <= '0;
                    words_loaded <= words_loaded + 1'b1;
                    word_addr    <= word_addr + 1'b1;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Frame parser that streams UART bytes into a word-organised SRAM and then
// releases the core reset. Checksum stage: define UART_MEM_LOADER_CHECKSUM_EN.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         BPW       = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         BASE_ADDR = 0,
    localparam int        DATA_W    = 8 * BPW
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              arm,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BPW-1:0]    mem_be,
    output logic              core_resetn,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    // Valid/ready: a byte transfers on any cycle with in_valid & in_ready; in_ready is
    // held high in every state so the receiver never stalls.
    state_t      state;
    state_t      state_next;
    logic [7:0]  count_lo;
    logic [15:0] count;
    logic        accept;
    logic        len_bad;
    logic        start_data;
    logic        fire;
    logic        clear;
    logic        word_done;
    logic        last_word;
    logic [15:0] count_new;

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif

    assign in_ready   = 1'b1;
    assign accept     = in_valid && in_ready;
    assign count_new  = {in_data, count_lo};
    assign len_bad    = (count_new == 16'd0) || ({1'b0, count_new} > (17'd1 << ADDR_W));
    assign start_data = !arm && accept && (state == LEN_HI) && !len_bad;
    assign fire       = !arm && accept && (state == DATA);
    assign clear      = arm || start_data;
    assign last_word  = word_done && ((17'(words_loaded) + 17'd1) == {1'b0, count});

    uart_mem_loader_lane #(
        .ADDR_W   (ADDR_W),
        .BPW      (BPW),
        .BASE_ADDR(BASE_ADDR)
    ) u_lane (
        .clk         (clk),
        .nRST        (nRST),
        .clear       (clear),
        .fire        (fire),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .words_loaded(words_loaded),
        .word_done   (word_done)
    );

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (arm) begin
            state_next = WAIT_SYNC;
        end else if (accept) begin
            case (state)
                WAIT_SYNC: if (in_data == SYNC_BYTE) state_next = LEN_LO;
                LEN_LO:    state_next = LEN_HI;
                LEN_HI:    state_next = len_bad ? ERROR : DATA;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                DATA:      if (last_word) state_next = CSUM;
                CSUM:      state_next = (in_data == sum) ? DONE : ERROR;
`else
                DATA:      if (last_word) state_next = DONE;
`endif
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            count_lo    <= '0;
            count       <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            core_resetn <= 1'b0;
        end else begin
            if (!arm && accept && state == LEN_LO) count_lo <= in_data;
            if (!arm && accept && state == LEN_HI) count <= count_new;
            mem_we <= fire;
            if (fire) mem_wdata <= {BPW{in_data}};
            core_resetn <= !arm && (state == DONE);
        end
    end

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!nRST) begin
            sum <= '0;
        end else if (start_data) begin
            sum <= '0;
        end else if (fire) begin
            sum <= sum + in_data;
        end
    end
`endif

    assign busy  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
    assign done  = (state == DONE);
    assign error = (state == ERROR);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: default instance plus a BASE_ADDR=1022 instance for wrap-around.
module tb_uart_mem_loader;
    import uart_mem_loader_pkg::*;

    localparam int ADDR_W = 10;
    localparam int BPW    = 4;
    localparam int DATA_W = 32;
    localparam int EW     = ADDR_W + BPW + DATA_W;

    logic clk;
    logic nRST;
    logic arm;
    logic in_valid;
    logic [7:0] in_data;
    logic sel;
    logic m_valid, w_valid;

    logic              m_ready, m_we, m_core, m_busy, m_done, m_error;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BPW-1:0]    m_be;
    logic [ADDR_W:0]   m_words;

    logic              w_ready, w_we, w_core, w_busy, w_done, w_error;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BPW-1:0]    w_be;
    logic [ADDR_W:0]   w_words;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] wexp_q[$];

    assign m_valid = in_valid & ~sel;
    assign w_valid = in_valid & sel;

    uart_mem_loader u_dut (
        .clk(clk), .nRST(nRST), .arm(arm), .in_valid(m_valid), .in_data(in_data),
        .in_ready(m_ready), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_be(m_be), .core_resetn(m_core), .busy(m_busy), .done(m_done),
        .error(m_error), .words_loaded(m_words)
    );

    uart_mem_loader #(.BASE_ADDR(1022)) u_wrap (
        .clk(clk), .nRST(nRST), .arm(arm), .in_valid(w_valid), .in_data(in_data),
        .in_ready(w_ready), .mem_we(w_we), .mem_addr(w_addr), .mem_wdata(w_wdata),
        .mem_be(w_be), .core_resetn(w_core), .busy(w_busy), .done(w_done),
        .error(w_error), .words_loaded(w_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboards: every mem_we pulse must match the head of its queue.
    always @(negedge clk) begin
        if (m_we === 1'b1) begin
            chk("main_write_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("main_write", 64'({m_addr, m_be, m_wdata}), 64'(exp_q.pop_front()));
        end
        if (w_we === 1'b1) begin
            chk("wrap_write_pending", 64'(wexp_q.size() != 0), 64'd1);
            if (wexp_q.size() != 0) chk("wrap_write", 64'({w_addr, w_be, w_wdata}), 64'(wexp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        send(b);
`else
        in_data = b;
`endif
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [BPW-1:0] be, input logic [7:0] b);
        exp_q.push_back({a, be, {4{b}}});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 64'(m_ready), 64'd1);
        chk({tag, "_we"}, 64'(m_we), 64'd0);
        chk({tag, "_addr"}, 64'(m_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(m_wdata), 64'd0);
        chk({tag, "_be"}, 64'(m_be), 64'd0);
        chk({tag, "_core"}, 64'(m_core), 64'd0);
        chk({tag, "_busy"}, 64'(m_busy), 64'd0);
        chk({tag, "_done"}, 64'(m_done), 64'd0);
        chk({tag, "_error"}, 64'(m_error), 64'd0);
        chk({tag, "_words"}, 64'(m_words), 64'd0);
        chk({tag, "_state"}, 64'(u_dut.state), 64'(WAIT_SYNC));
    endtask

    initial begin
        logic [7:0] pay_a [8];
        logic [ADDR_W-1:0] wa;
        pay_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        sel = 1'b0; arm = 1'b0; in_valid = 1'b0; in_data = 8'h00; nRST = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        nRST = 1'b1;
        tick();

        // Two-word frame, back-to-back bytes
        send(8'h53);
        chk("a_busy_len", 64'(m_busy), 64'd1);
        send(8'h02); send(8'h00);
        chk("a_state_data", 64'(u_dut.state), 64'(DATA));
        for (int i = 0; i < 8; i++) push(ADDR_W'(i / 4), BPW'(1 << (i % 4)), pay_a[i]);
        for (int i = 0; i < 8; i++) send(pay_a[i]);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        chk("a_busy_csum", 64'(m_busy), 64'd1);
`else
        chk("a_last_be", 64'(m_be), 64'h8);
        chk("a_last_addr", 64'(m_addr), 64'd1);
`endif
        send_csum(8'h64);
        chk("a_done", 64'(m_done), 64'd1);
        chk("a_core_early", 64'(m_core), 64'd0);
        chk("a_words", 64'(m_words), 64'd2);
        tick();
        chk("a_core_run", 64'(m_core), 64'd1);
        send(8'h53);
        chk("a_done_hold", 64'(m_done), 64'd1);
        chk("a_core_hold", 64'(m_core), 64'd1);
        pulse_arm();
        chk("arm_state", 64'(u_dut.state), 64'(WAIT_SYNC));
        chk("arm_core", 64'(m_core), 64'd0);
        chk("arm_words", 64'(m_words), 64'd0);

        // Noise before sync
        send(8'h00); send(8'hFF);
        chk("n_state", 64'(u_dut.state), 64'(WAIT_SYNC));
        send(8'h53); send(8'h01); send(8'h00);
        push(0, 4'h1, 8'hAA); push(0, 4'h2, 8'hBB); push(0, 4'h4, 8'hCC); push(0, 4'h8, 8'hDD);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send_csum(8'h0E);
        chk("n_done", 64'(m_done), 64'd1);
        chk("n_words", 64'(m_words), 64'd1);
        pulse_arm();

        // Bad lengths, plus the largest legal length
        send(8'h53); send(8'h00); send(8'h00);
        chk("z_error", 64'(m_error), 64'd1);
        chk("z_busy", 64'(m_busy), 64'd0);
        tick();
        chk("z_core", 64'(m_core), 64'd0);
        send(8'h55);
        chk("z_error_hold", 64'(m_error), 64'd1);
        chk("z_ready", 64'(m_ready), 64'd1);
        pulse_arm();
        chk("z_error_clr", 64'(m_error), 64'd0);
        send(8'h53); send(8'h01); send(8'h04);
        chk("big_error", 64'(m_error), 64'd1);
        pulse_arm();
        send(8'h53); send(8'h00); send(8'h04);
        chk("max_len_state", 64'(u_dut.state), 64'(DATA));
        pulse_arm();

        // Abort mid-frame while a write is pending
        send(8'h53); send(8'h02); send(8'h00);
        push(0, 4'h1, 8'h11); push(0, 4'h2, 8'h22); push(0, 4'h4, 8'h33);
        send(8'h11); send(8'h22);
        in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0; arm = 1'b1;
        chk("ab_we_pending", 64'(m_we), 64'd1);
        tick();
        arm = 1'b0;
        chk("ab_state", 64'(u_dut.state), 64'(WAIT_SYNC));
        chk("ab_core", 64'(m_core), 64'd0);
        chk("ab_words", 64'(m_words), 64'd0);
        chk("ab_busy", 64'(m_busy), 64'd0);
        arm = 1'b1; in_valid = 1'b1; in_data = 8'h53;
        tick();
        arm = 1'b0; in_valid = 1'b0;
        chk("ab_sync_dropped", 64'(u_dut.state), 64'(WAIT_SYNC));
        send(8'h53); send(8'h01); send(8'h00);
        push(0, 4'h1, 8'h01); push(0, 4'h2, 8'h02); push(0, 4'h4, 8'h03); push(0, 4'h8, 8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send_csum(8'h0A);
        chk("fresh_done", 64'(m_done), 64'd1);
        chk("fresh_addr", 64'(m_addr), 64'd0);
        pulse_arm();

`ifdef UART_MEM_LOADER_CHECKSUM_EN
        send(8'h53); send(8'h01); send(8'h00);
        push(0, 4'h1, 8'h01); push(0, 4'h2, 8'h02); push(0, 4'h4, 8'h03); push(0, 4'h8, 8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h0B);
        chk("cs_bad_error", 64'(m_error), 64'd1);
        tick();
        chk("cs_bad_core", 64'(m_core), 64'd0);
        pulse_arm();
`endif

        // Address wrap on the BASE_ADDR=1022 instance
        sel = 1'b1;
        send(8'h53); send(8'h04); send(8'h00);
        for (int i = 0; i < 16; i++) begin
            wa = ADDR_W'(1022 + i / 4);
            wexp_q.push_back({wa, BPW'(1 << (i % 4)), {4{8'(8'h10 + i)}}});
        end
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        send_csum(8'h78);
        chk("wrap_done", 64'(w_done), 64'd1);
        chk("wrap_words", 64'(w_words), 64'd4);
        chk("wrap_last_addr", 64'(w_addr), 64'd1);
        sel = 1'b0;
        pulse_arm();

        // Reset in the middle of a load
        send(8'h53); send(8'h01); send(8'h00);
        push(0, 4'h1, 8'hA1);
        in_valid = 1'b1; in_data = 8'hA1;
        tick();
        in_valid = 1'b0; nRST = 1'b0;
        chk("mr_we_pending", 64'(m_we), 64'd1);
        tick();
        check_reset("mr");
        nRST = 1'b1;
        tick();

        chk("main_q_empty", 64'(exp_q.size()), 64'd0);
        chk("wrap_q_empty", 64'(wexp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
